// File: rtl/synapse_mac.sv
// synapse_mac: weighted spike accumulator feeding a neuron's membrane input.
// A start request latches the spike vector, then one weight per cycle is
// conditionally added into a saturating accumulator; the final sum is
// presented with a one-cycle out_valid pulse.
// Optional feature macro: SYNAPSE_MAC_INHIB_EN (signed weights, clamp at 0).
module synapse_mac #(
  parameter int unsigned NUM_IN       = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned MAX_VAL      = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_IN)-1:0] wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]   wr_data,
  input  logic                      in_start,
  input  logic [NUM_IN-1:0]         in_spikes,
  output logic                      busy,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_mac_sum
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned WW    = WEIGHT_WIDTH;
  // Two bits of headroom: one for carry, one for sign in the inhibitory build.
  localparam int unsigned SUM_W = ((DW > WW) ? DW : WW) + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WW-1:0]     weight_q [NUM_IN];
  logic [NUM_IN-1:0] spikes_q, spikes_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     sum_q, sum_d;

  logic [WW-1:0]     w_cur;
  logic [DW-1:0]     acc_add;
`ifdef SYNAPSE_MAC_INHIB_EN
  logic signed [SUM_W-1:0] sum_s;
`else
  logic [SUM_W-1:0]        sum_u;
`endif

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_mac_sum = sum_q;

  // Weight store: writable in every state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_IN); i++) begin
        weight_q[i] <= '0;
      end
    end else if (wr_en) begin
      weight_q[wr_addr] <= wr_data;
    end
  end

  // Saturating conditional add of the current weight (reads pre-write contents).
  always_comb begin
    w_cur   = weight_q[idx_q];
    acc_add = acc_q;
`ifdef SYNAPSE_MAC_INHIB_EN
    sum_s = $signed(SUM_W'(acc_q)) + $signed({{(SUM_W-WW){w_cur[WW-1]}}, w_cur});
    if (spikes_q[idx_q]) begin
      if (sum_s < $signed(SUM_W'(0))) begin
        acc_add = '0;
      end else if (sum_s >= $signed(SUM_W'(MAX_VAL))) begin
        acc_add = DW'(MAX_VAL);
      end else begin
        acc_add = DW'(sum_s);
      end
    end
`else
    sum_u = SUM_W'(acc_q) + SUM_W'(w_cur);
    if (spikes_q[idx_q]) begin
      if (sum_u >= SUM_W'(MAX_VAL)) begin
        acc_add = DW'(MAX_VAL);
      end else begin
        acc_add = DW'(sum_u);
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to idle.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = in_start ? S_ACCUM : S_IDLE;
      S_ACCUM: state_d = (idx_q == LAST_IDX) ? S_DONE : S_ACCUM;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    spikes_d = spikes_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    busy_d   = (state_d == S_ACCUM);
    valid_d  = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          spikes_d = in_spikes;
          acc_d    = '0;
          idx_d    = '0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_add;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d = acc_add;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      spikes_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sum_q    <= '0;
    end else begin
      spikes_q <= spikes_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: tb/tb_synapse_mac.sv
// tb_synapse_mac: directed vectors with hand-computed sums for synapse_mac.
// Honours SYNAPSE_MAC_INHIB_EN for the inhibitory-weight vector.
module tb_synapse_mac;

  localparam int unsigned NUM_IN = 16;
  localparam int unsigned DW     = 8;
  localparam int unsigned WW     = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [WW-1:0] wr_data;
  logic          in_start;
  logic [15:0]   in_spikes;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_mac_sum;

  int n_total = 0;
  int n_bad   = 0;

  synapse_mac #(
    .NUM_IN(NUM_IN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .MAX_VAL(100)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_start(in_start), .in_spikes(in_spikes), .busy(busy),
    .out_valid(out_valid), .out_mac_sum(out_mac_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = WW'(data);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic set_all(input int data);
    for (int i = 0; i < 16; i++) write_w(i, data);
  endtask

  // One accumulation; optional ignored start at xs_step and weight write at wr_step.
  task automatic run(input logic [15:0] sp, input int xs_step, input int wr_step,
                     input int wa, input int wd,
                     output int sum, output int busy_cnt, output int lat,
                     output int pulses);
    busy_cnt = 0; lat = -1; pulses = 0; sum = -1;
    in_start  = 1'b1;
    in_spikes = sp;
    step();
    in_start  = 1'b0;
    in_spikes = 16'h0;
    for (int k = 1; k <= 25; k++) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        pulses++;
        if (lat < 0) lat = k;
        sum = int'(out_mac_sum);
      end
      in_start  = (k == xs_step);
      in_spikes = (k == xs_step) ? 16'hFFFF : 16'h0;
      wr_en     = (k == wr_step);
      wr_addr   = 4'(wa);
      wr_data   = WW'(wd);
      step();
    end
    in_start = 1'b0;
    wr_en    = 1'b0;
  endtask

  int s, b, l, p;
  int exp035;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_start = 1'b0; in_spikes = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_sum", int'(out_mac_sum), 0);

    // Half the inputs firing onto weight 5.
    set_all(5);
    run(16'h00FF, 0, 0, 0, 0, s, b, l, p);
    check("w5_sum", s, 40);
    check("w5_busy_cycles", b, 16);
    check("w5_latency", l, 17);
    check("w5_pulses", p, 1);
    step(); step();
    check("w5_hold", int'(out_mac_sum), 40);

    // Write to the index being read lands after that read.
    run(16'h0001, 0, 1, 0, 77, s, b, l, p);
    check("wr_same_edge_sum", s, 5);
    run(16'h0001, 0, 0, 0, 0, s, b, l, p);
    check("wr_later_sum", s, 77);
    run(16'h8001, 0, 0, 0, 0, s, b, l, p);
    check("first_last_sum", s, 82);

    // Saturation at the ceiling.
    set_all(20);
    run(16'hFFFF, 0, 0, 0, 0, s, b, l, p);
    check("sat_sum", s, 100);
    check("sat_pulses", p, 1);
    run(16'h000F, 0, 0, 0, 0, s, b, l, p);
    check("below_sat_sum", s, 80);

    // Zero spikes still pulse; a start while busy is ignored.
    run(16'h0000, 5, 0, 0, 0, s, b, l, p);
    check("zero_sum", s, 0);
    check("zero_latency", l, 17);
    check("zero_pulses", p, 1);
    check("zero_idle_after", int'(busy), 0);

    // Reset mid-accumulation, competing with a write and a start.
    in_start = 1'b1; in_spikes = 16'hFFFF;
    step();
    in_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd99; in_start = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0; in_start = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_sum", int'(out_mac_sum), 0);
    p = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid || busy) p++;
      step();
    end
    check("abort_no_activity", p, 0);
    run(16'hFFFF, 0, 0, 0, 0, s, b, l, p);
    check("post_rst_weights_zero", s, 0);
    check("post_rst_pulses", p, 1);

    // Inhibitory weight handling.
    write_w(0, 50);
    write_w(1, 8'hB0);
    write_w(2, 30);
`ifdef SYNAPSE_MAC_INHIB_EN
    exp035 = 30;
`else
    exp035 = 100;
`endif
    run(16'h0007, 0, 0, 0, 0, s, b, l, p);
    check("inhib_sum", s, exp035);
    check("inhib_pulses", p, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
